// File: rtl/status_monitor_pkg.sv
// Shared types and constants for the status line monitor: FSM encoding,
// default parameter values and the saturation-limit helper.
package status_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2,
        StStuck   = 2'd3
    } state_e;

    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefTimeout    = 1000;
    localparam int unsigned DefSyncStages = 2;

    // All-ones value of a counter of the given width, used as the saturation limit.
    function automatic logic [63:0] sat_max(input int unsigned width);
        logic [63:0] one;
        one = 64'd1;
        if (width >= 64) begin
            return '1;
        end
        return (one << width) - one;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; reset value is 0.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two flops gives no metastability protection, so clamp upwards.
    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/status_monitor.sv
// Measures the width of each stable level on an asynchronous status line and
// hands completed pulse records out through a single-entry valid/ready stage.
module status_monitor
    import status_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned TIMEOUT     = DefTimeout,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             status_in,
    input  logic             enable,
    input  logic             clear,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             meas_level,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] edge_count,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CntMax     = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam bit               TimeoutEn  = (TIMEOUT != 0);

    logic s;
    logic s_dly_q, s_dly_d;
    logic edge_det;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             rec_vld;

    logic             valid_q, valid_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             hs;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (status_in),
        .q  (s)
    );

    assign edge_det = (s != s_dly_q);
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);

    // FSM, width counter and timeout flag.
    always_comb begin
        s_dly_d   = s;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_vld   = 1'b0;
        timeout_d = timeout_q;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
                StArm: begin
                    // The level in progress when arming has an unknown start, so drop it.
                    if (edge_det) begin
                        state_d = StMeasure;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StMeasure: begin
                    if (edge_det) begin
                        cnt_d   = CntOne;
                        rec_vld = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (TimeoutEn && (cnt_q == TimeoutVal)) begin
                            state_d   = StStuck;
                            timeout_d = 1'b1;
                        end
                    end
                end
                StStuck: begin
                    if (edge_det) begin
                        state_d   = StMeasure;
                        cnt_d     = CntOne;
                        timeout_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        if (clear) begin
            timeout_d = 1'b0;
        end
    end

    // Edge counter and single-entry output stage.
    always_comb begin
        hs         = valid_q & meas_ready;
        valid_d    = valid_q;
        level_d    = level_q;
        width_d    = width_q;
        overrun_d  = overrun_q;
        edge_cnt_d = edge_cnt_q;

        if (clear) begin
            edge_cnt_d = '0;
        end else if (enable && (state_q != StIdle) && edge_det) begin
            edge_cnt_d = edge_cnt_q + CntOne;
        end

        if (rec_vld) begin
            if (!valid_q || hs) begin
                valid_d = 1'b1;
                level_d = s_dly_q;
                width_d = cnt_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_dly_q    <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            level_q    <= 1'b0;
            width_q    <= '0;
            edge_cnt_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            s_dly_q    <= s_dly_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            level_q    <= level_d;
            width_q    <= width_d;
            edge_cnt_q <= edge_cnt_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign meas_valid = valid_q;
    assign meas_level = level_q;
    assign meas_width = width_q;
    assign edge_count = edge_cnt_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_status_monitor.sv
// Bench for status_monitor: pulse table with a record scoreboard, plus hand-written
// sequences for backpressure, clear, stuck line, saturation and mid-run reset.
module tb_status_monitor;
    import status_monitor_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_status, a_enable, a_clear, a_ready;
    logic          a_valid, a_level, a_overrun, a_timeout;
    logic [AW-1:0] a_width, a_edges;

    logic          b_status, b_enable, b_clear, b_ready;
    logic          b_valid, b_level, b_overrun, b_timeout;
    logic [BW-1:0] b_width, b_edges;

    status_monitor #(
        .CNT_W      (AW),
        .TIMEOUT    (64),
        .SYNC_STAGES(2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .status_in (a_status),
        .enable    (a_enable),
        .clear     (a_clear),
        .meas_valid(a_valid),
        .meas_ready(a_ready),
        .meas_level(a_level),
        .meas_width(a_width),
        .edge_count(a_edges),
        .overrun   (a_overrun),
        .timeout   (a_timeout)
    );

    status_monitor #(
        .CNT_W      (BW),
        .TIMEOUT    (0),
        .SYNC_STAGES(2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .status_in (b_status),
        .enable    (b_enable),
        .clear     (b_clear),
        .meas_valid(b_valid),
        .meas_ready(b_ready),
        .meas_level(b_level),
        .meas_width(b_width),
        .edge_count(b_edges),
        .overrun   (b_overrun),
        .timeout   (b_timeout)
    );

    typedef struct {
        logic        lvl;
        int unsigned w;
    } rec_t;

    typedef struct {
        logic        lvl;
        int unsigned dur;
        bit          rec;
    } vec_t;

    rec_t a_q[$];
    rec_t b_q[$];
    rec_t a_exp, b_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   b_to_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_a(input logic lvl, input int unsigned w);
        rec_t r;
        r.lvl = lvl;
        r.w   = w;
        a_q.push_back(r);
    endtask

    // Record scoreboards: a handshake is decided at the next rising edge.
    always @(negedge clk) begin
        if (!rst && a_valid && a_ready) begin
            if (a_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_record: got (%0d,%0d), required none",
                         a_level, a_width);
            end else begin
                a_exp = a_q.pop_front();
                check("a_rec_level", 32'(a_level), 32'(a_exp.lvl));
                check("a_rec_width", 32'(a_width), a_exp.w);
            end
        end
        if (!rst && b_valid && b_ready) begin
            if (b_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_record: got (%0d,%0d), required none",
                         b_level, b_width);
            end else begin
                b_exp = b_q.pop_front();
                check("b_rec_level", 32'(b_level), 32'(b_exp.lvl));
                check("b_rec_width", 32'(b_width), b_exp.w);
            end
        end
        if (b_timeout === 1'b1) begin
            b_to_seen = 1'b1;
        end
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{lvl: 1'b0, dur: 20, rec: 1'b0};
        vecs[1] = '{lvl: 1'b1, dur: 10, rec: 1'b1};
        vecs[2] = '{lvl: 1'b0, dur: 5,  rec: 1'b1};
        vecs[3] = '{lvl: 1'b1, dur: 1,  rec: 1'b1};
        vecs[4] = '{lvl: 1'b0, dur: 1,  rec: 1'b1};
        vecs[5] = '{lvl: 1'b1, dur: 63, rec: 1'b1};
        vecs[6] = '{lvl: 1'b0, dur: 2,  rec: 1'b1};
        vecs[7] = '{lvl: 1'b1, dur: 30, rec: 1'b1};
        vecs[8] = '{lvl: 1'b0, dur: 12, rec: 1'b0};

        rst      = 1'b1;
        a_status = 1'b0; a_enable = 1'b0; a_clear = 1'b0; a_ready = 1'b0;
        b_status = 1'b0; b_enable = 1'b0; b_clear = 1'b0; b_ready = 1'b0;
        step(3);
        check("rst_valid",   32'(a_valid),   32'd0);
        check("rst_level",   32'(a_level),   32'd0);
        check("rst_width",   32'(a_width),   32'd0);
        check("rst_edges",   32'(a_edges),   32'd0);
        check("rst_overrun", 32'(a_overrun), 32'd0);
        check("rst_timeout", 32'(a_timeout), 32'd0);
        rst = 1'b0;
        step(2);

        // Saturation on the 4-bit instance with timeout disabled.
        b_enable = 1'b1;
        b_ready  = 1'b1;
        step(5);
        b_status = 1'b1;
        b_q.push_back('{lvl: 1'b1, w: 15});
        step(20);
        b_status = 1'b0;
        step(10);
        check("b_queue_drained", 32'(b_q.size()), 32'd0);
        check("b_edges",         32'(b_edges),    32'd2);
        check("b_overrun",       32'(b_overrun),  32'd0);

        // Pulse table with the consumer always ready.
        a_enable = 1'b1;
        a_ready  = 1'b1;
        foreach (vecs[i]) begin
            a_status = vecs[i].lvl;
            if (vecs[i].rec) begin
                push_a(vecs[i].lvl, vecs[i].dur);
            end
            step(int'(vecs[i].dur));
        end
        check("tbl_edges",   32'(a_edges),   32'd8);
        check("tbl_overrun", 32'(a_overrun), 32'd0);
        check("tbl_timeout", 32'(a_timeout), 32'd0);
        a_enable = 1'b0;
        step(3);
        check("tbl_valid_idle", 32'(a_valid),    32'd0);
        check("tbl_queue",      32'(a_q.size()), 32'd0);

        // Backpressure: first record held, second dropped.
        a_ready = 1'b0;
        a_clear = 1'b1;
        step(1);
        a_clear = 1'b0;
        check("clr_edges_idle", 32'(a_edges), 32'd0);
        a_enable = 1'b1;
        a_status = 1'b0; step(20);
        a_status = 1'b1; step(10);
        a_status = 1'b0; step(5);
        a_status = 1'b1; step(6);
        check("bp_valid",   32'(a_valid),   32'd1);
        check("bp_level",   32'(a_level),   32'd1);
        check("bp_width",   32'(a_width),   32'd10);
        check("bp_overrun", 32'(a_overrun), 32'd1);
        check("bp_edges",   32'(a_edges),   32'd3);
        // Clear lands in the same cycle as an edge and a dropped record.
        a_status = 1'b0;
        step(2);
        a_clear = 1'b1;
        step(1);
        a_clear = 1'b0;
        check("clr_edges",   32'(a_edges),   32'd0);
        check("clr_overrun", 32'(a_overrun), 32'd0);
        check("clr_valid",   32'(a_valid),   32'd1);
        check("clr_level",   32'(a_level),   32'd1);
        check("clr_width",   32'(a_width),   32'd10);
        push_a(1'b1, 10);
        a_ready = 1'b1;
        step(1);
        a_ready = 1'b0;
        check("drain_valid", 32'(a_valid), 32'd0);

        // Consume and load in the same cycle.
        a_enable = 1'b0;
        step(2);
        a_enable = 1'b1;
        step(10);
        a_status = 1'b1; step(6);
        a_status = 1'b0; step(7);
        push_a(1'b1, 6);
        a_status = 1'b1;
        step(2);
        a_ready = 1'b1;
        step(1);
        check("sim_valid",   32'(a_valid),   32'd1);
        check("sim_level",   32'(a_level),   32'd0);
        check("sim_width",   32'(a_width),   32'd7);
        check("sim_overrun", 32'(a_overrun), 32'd0);
        push_a(1'b0, 7);

        // Stuck high: timeout rises the cycle after the count reaches 64.
        step(63);
        check("stuck_early", 32'(a_timeout), 32'd0);
        step(1);
        check("stuck_set", 32'(a_timeout), 32'd1);
        step(33);
        check("stuck_norec", 32'(a_valid),    32'd0);
        check("stuck_queue", 32'(a_q.size()), 32'd0);
        a_status = 1'b0;
        step(8);
        check("stuck_cleared", 32'(a_timeout), 32'd0);
        a_status = 1'b1;
        push_a(1'b0, 8);
        step(10);
        check("stuck_after_queue", 32'(a_q.size()), 32'd0);

        // Asynchronous reset with a record pending.
        a_ready = 1'b0;
        step(5);
        a_status = 1'b0;
        step(6);
        check("prerst_valid", 32'(a_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_valid",   32'(a_valid),       32'd0);
        check("mrst_level",   32'(a_level),       32'd0);
        check("mrst_width",   32'(a_width),       32'd0);
        check("mrst_edges",   32'(a_edges),       32'd0);
        check("mrst_overrun", 32'(a_overrun),     32'd0);
        check("mrst_timeout", 32'(a_timeout),     32'd0);
        check("mrst_state",   32'(dut_a.state_q), 32'(StIdle));
        step(2);
        rst = 1'b0;
        check("post_rst_state", 32'(dut_a.state_q), 32'(StIdle));
        step(3);
        check("post_rst_valid", 32'(a_valid), 32'd0);

        check("b_timeout_never", 32'(b_to_seen), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
